// File: rtl/usb_desc_pkg.sv
// usb_desc_pkg: shared constants and types for the USB descriptor streamer.
//   - descriptor type codes (wValue high byte / bDescriptorType)
//   - endpoint transfer-type codes (bmAttributes[1:0])
//   - descriptor lengths and the Configuration bundle total
//   - streamer state encoding and the latched request-field record
package usb_desc_pkg;

    localparam logic [7:0] DESC_DEVICE        = 8'h01;
    localparam logic [7:0] DESC_CONFIGURATION = 8'h02;
    localparam logic [7:0] DESC_STRING        = 8'h03;
    localparam logic [7:0] DESC_INTERFACE     = 8'h04;
    localparam logic [7:0] DESC_ENDPOINT      = 8'h05;

    localparam logic [1:0] XFER_CONTROL     = 2'd0;
    localparam logic [1:0] XFER_ISOCHRONOUS = 2'd1;
    localparam logic [1:0] XFER_BULK        = 2'd2;
    localparam logic [1:0] XFER_INTERRUPT   = 2'd3;

    localparam logic [15:0] DEV_LEN   = 16'd18;
    localparam logic [15:0] CFG_LEN   = 16'd9;
    localparam logic [15:0] IF_LEN    = 16'd9;
    localparam logic [15:0] EP_LEN    = 16'd7;
    localparam logic [15:0] CFG_TOTAL = 16'd25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } desc_state_t;

    typedef struct packed {
        logic [7:0]  iface_number;
        logic [7:0]  iface_class;
        logic [7:0]  iface_subclass;
        logic [7:0]  iface_protocol;
        logic [7:0]  ep_addr;
        logic [7:0]  ep_attr;
        logic [10:0] ep_max_packet;
        logic [7:0]  ep_interval;
    } desc_fields_t;

    localparam desc_fields_t FIELDS_RESET = {$bits(desc_fields_t){1'b0}};

    // Full serialised length of a supported descriptor; 0 marks an unsupported type.
    function automatic logic [15:0] native_len(input logic [7:0] desc_type);
        logic [15:0] len;
        case (desc_type)
            DESC_DEVICE:        len = DEV_LEN;
            DESC_CONFIGURATION: len = CFG_TOTAL;
            default:            len = 16'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/usb_desc_byte_mux.sv
// usb_desc_byte_mux: combinational lookup of one descriptor byte.
//   desc_type : descriptor selector (Device / Configuration bundle)
//   index     : byte offset inside the serialised descriptor
//   fields    : latched interface/endpoint fields of the current request
//   data      : byte at that offset (0 for out-of-range offsets or types)
module usb_desc_byte_mux
    import usb_desc_pkg::*;
#(
    parameter logic [15:0] VID        = 16'h1209,
    parameter logic [15:0] PID        = 16'h0001,
    parameter logic [15:0] BCD_DEVICE = 16'h0100,
    parameter logic [7:0]  EP0_MPS    = 8'd64,
    parameter logic [7:0]  CFG_ATTR   = 8'hA0,
    parameter logic [7:0]  MAX_POWER  = 8'd50
) (
    input  logic [7:0]   desc_type,
    input  logic [7:0]   index,
    input  desc_fields_t fields,
    output logic [7:0]   data
);

    // Byte map: Device descriptor, or Config + Interface + Endpoint back to back.
    always_comb begin
        data = 8'h00;
        if (desc_type == DESC_DEVICE) begin
            case (index)
                8'd0:    data = DEV_LEN[7:0];
                8'd1:    data = DESC_DEVICE;
                8'd2:    data = 8'h00;            // bcdUSB 2.00
                8'd3:    data = 8'h02;
                8'd7:    data = EP0_MPS;
                8'd8:    data = VID[7:0];
                8'd9:    data = VID[15:8];
                8'd10:   data = PID[7:0];
                8'd11:   data = PID[15:8];
                8'd12:   data = BCD_DEVICE[7:0];
                8'd13:   data = BCD_DEVICE[15:8];
                8'd17:   data = 8'h01;            // bNumConfigurations
                default: data = 8'h00;
            endcase
        end else if (desc_type == DESC_CONFIGURATION) begin
            case (index)
                8'd0:    data = CFG_LEN[7:0];
                8'd1:    data = DESC_CONFIGURATION;
                8'd2:    data = CFG_TOTAL[7:0];   // wTotalLength
                8'd3:    data = CFG_TOTAL[15:8];
                8'd4:    data = 8'h01;            // bNumInterfaces
                8'd5:    data = 8'h01;            // bConfigurationValue
                8'd7:    data = CFG_ATTR;
                8'd8:    data = MAX_POWER;
                8'd9:    data = IF_LEN[7:0];
                8'd10:   data = DESC_INTERFACE;
                8'd11:   data = fields.iface_number;
                8'd13:   data = 8'h01;            // bNumEndpoints
                8'd14:   data = fields.iface_class;
                8'd15:   data = fields.iface_subclass;
                8'd16:   data = fields.iface_protocol;
                8'd18:   data = EP_LEN[7:0];
                8'd19:   data = DESC_ENDPOINT;
                8'd20:   data = fields.ep_addr;
                8'd21:   data = fields.ep_attr;
                8'd22:   data = fields.ep_max_packet[7:0];
                8'd23:   data = {5'b00000, fields.ep_max_packet[10:8]};
                8'd24:   data = fields.ep_interval;
                default: data = 8'h00;
            endcase
        end else begin
            data = 8'h00;
        end
    end

endmodule

// File: rtl/usb_descriptor_builder.sv
// usb_descriptor_builder: streams a GET_DESCRIPTOR response over valid/ready.
//   start/req_type/req_length : request from the EP0 control decoder
//   iface_* / ep_*            : interface and endpoint fields, latched on start
//   desc_data/valid/ready/last: byte stream to the EP0 IN packetiser
//   busy  : request in progress;  done : completion pulse;  stall : unsupported type pulse
// All outputs are registered; byte i of the response appears the cycle after
// the request (i == 0) or after the transfer of byte i-1.
module usb_descriptor_builder
    import usb_desc_pkg::*;
#(
    parameter logic [15:0] VID        = 16'h1209,
    parameter logic [15:0] PID        = 16'h0001,
    parameter logic [15:0] BCD_DEVICE = 16'h0100,
    parameter logic [7:0]  EP0_MPS    = 8'd64,
    parameter logic [7:0]  CFG_ATTR   = 8'hA0,
    parameter logic [7:0]  MAX_POWER  = 8'd50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  req_type,
    input  logic [15:0] req_length,
    input  logic [7:0]  iface_number,
    input  logic [7:0]  iface_class,
    input  logic [7:0]  iface_subclass,
    input  logic [7:0]  iface_protocol,
    input  logic [7:0]  ep_addr,
    input  logic [7:0]  ep_attr,
    input  logic [10:0] ep_max_packet,
    input  logic [7:0]  ep_interval,
    output logic [7:0]  desc_data,
    output logic        desc_valid,
    input  logic        desc_ready,
    output logic        desc_last,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    desc_state_t  state_r, state_s;
    logic [7:0]   idx_r, idx_s;
    logic [7:0]   tx_len_r, tx_len_s;
    logic [7:0]   type_r, type_s;
    desc_fields_t fields_r, fields_s;
    logic [15:0]  native_len_s;
    logic [7:0]   clip_len_s;
    logic [7:0]   mux_byte_s;
    logic [7:0]   desc_data_r;
    logic         desc_valid_r, desc_last_r, busy_r, done_r, stall_r;

    // Next-state logic; the byte mux looks at next-cycle index/fields so the output byte can be registered.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        tx_len_s     = tx_len_r;
        type_s       = type_r;
        fields_s     = fields_r;
        native_len_s = native_len(req_type);
        // Compare on the full 16-bit wLength; the clipped value always fits in 8 bits.
        if (req_length < native_len_s) begin
            clip_len_s = req_length[7:0];
        end else begin
            clip_len_s = native_len_s[7:0];
        end
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    type_s                  = req_type;
                    tx_len_s                = clip_len_s;
                    idx_s                   = 8'd0;
                    fields_s.iface_number   = iface_number;
                    fields_s.iface_class    = iface_class;
                    fields_s.iface_subclass = iface_subclass;
                    fields_s.iface_protocol = iface_protocol;
                    fields_s.ep_addr        = ep_addr;
                    fields_s.ep_attr        = ep_attr;
                    fields_s.ep_max_packet  = ep_max_packet;
                    fields_s.ep_interval    = ep_interval;
                    if (native_len_s == 16'd0) begin
                        state_s = ST_ERR;
                    end else if (clip_len_s == 8'd0) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SEND;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (desc_valid_r && desc_ready) begin
                    if (idx_r == tx_len_r - 8'd1) begin
                        state_s = ST_DONE;
                    end else begin
                        idx_s   = idx_r + 8'd1;
                        state_s = ST_SEND;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            ST_ERR:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    usb_desc_byte_mux #(
        .VID        (VID),
        .PID        (PID),
        .BCD_DEVICE (BCD_DEVICE),
        .EP0_MPS    (EP0_MPS),
        .CFG_ATTR   (CFG_ATTR),
        .MAX_POWER  (MAX_POWER)
    ) u_byte_mux (
        .desc_type (type_s),
        .index     (idx_s),
        .fields    (fields_s),
        .data      (mux_byte_s)
    );

    // State, index and latched request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            idx_r    <= 8'd0;
            tx_len_r <= 8'd0;
            type_r   <= 8'd0;
            fields_r <= FIELDS_RESET;
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            tx_len_r <= tx_len_s;
            type_r   <= type_s;
            fields_r <= fields_s;
        end
    end

    // Registered stream and status outputs, derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            desc_data_r  <= 8'h00;
            desc_valid_r <= 1'b0;
            desc_last_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            stall_r      <= 1'b0;
        end else begin
            desc_data_r  <= (state_s == ST_SEND) ? mux_byte_s : 8'h00;
            desc_valid_r <= (state_s == ST_SEND);
            desc_last_r  <= (state_s == ST_SEND) && (idx_s == tx_len_s - 8'd1);
            busy_r       <= (state_s != ST_IDLE);
            done_r       <= (state_s == ST_DONE);
            stall_r      <= (state_s == ST_ERR);
        end
    end

    assign desc_data  = desc_data_r;
    assign desc_valid = desc_valid_r;
    assign desc_last  = desc_last_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign stall      = stall_r;

endmodule
